// File: rtl/serv_bufreg_wide.sv
// serv_bufreg_wide: width-parametrised self-sequencing buffer register for the digit-serial core.
// Accumulates rs1+imm, shifts right/left or holds over 32/W beats per pass.
module serv_bufreg_wide #(
  parameter int W   = 1,
  parameter bit MDU = 1'b1,
  parameter int B   = W-1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [1:0]  i_mode,
  input  logic        i_rs1_en,
  input  logic        i_imm_en,
  input  logic        i_clr_lsb,
  input  logic        i_sh_signed,
  input  logic        i_mdu_op,
  input  logic [B:0]  i_rs1,
  input  logic [B:0]  i_imm,
  output logic [B:0]  o_q,
  output logic        o_busy,
  output logic        o_done,
  output logic [1:0]  o_lsb,
  output logic [31:0] o_dbus_adr,
  output logic [31:0] o_ext_rs1
);
  localparam int N  = 32 / W;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic [31:0]   data_q, data_d;
  logic [B:0]    clr_mask;
  logic [W:0]    sum;
  logic [31:0]   data_top;
  always_comb begin
    clr_mask = W'((cnt_q == '0) && i_clr_lsb);
    sum      = {1'b0, i_rs1 & {W{i_rs1_en}}} + {1'b0, i_imm & {W{i_imm_en}} & ~clr_mask} + (W+1)'(carry_q);
    data_top = data_q >> (32 - W);
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    data_d   = data_q;
    o_q      = '0;
    case (state_q)
      IDLE: if (i_start) begin
        state_d = RUN;
        cnt_d   = '0;
        carry_d = 1'b0;
      end
      RUN: begin
        cnt_d   = cnt_q + CW'(1);
        state_d = (cnt_q == CW'(N-1)) ? DONE : RUN;
        case (i_mode)
          2'b00: begin
            data_d  = (data_q >> W) | (32'(sum[B:0]) << (32 - W));
            carry_d = sum[W];
            o_q     = data_q[B:0];
          end
          2'b01: begin
            // Vacated top digit is filled with the sign bit for arithmetic shifts
            data_d = (data_q >> W) | ({32{data_q[31] & i_sh_signed}} & ~(32'hFFFF_FFFF >> W));
            o_q    = data_q[B:0];
          end
          2'b10: begin
            data_d = data_q << W;
            o_q    = data_top[B:0];
          end
          default: ;
        endcase
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      data_q  <= data_d;
    end
  end
  assign o_busy     = (state_q == RUN);
  assign o_done     = (state_q == DONE);
  assign o_lsb      = (MDU && i_mdu_op) ? 2'b00 : data_q[1:0];
  assign o_dbus_adr = {data_q[31:2], 2'b00};
  assign o_ext_rs1  = data_q;
endmodule

// File: tb/tb_serv_bufreg_wide.sv
// tb_serv_bufreg_wide: table-driven and scoreboarded bench for a W=4/MDU=1 and a W=1/MDU=0 instance.
module tb_serv_bufreg_wide;
  logic        clk = 1'b0, rst_n = 1'b0, start4 = 1'b0, start1 = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        rs1_en = 1'b0, imm_en = 1'b0, clr = 1'b0, sgn = 1'b0, mdu_op = 1'b0;
  logic [3:0]  rs1_4 = '0, imm_4 = '0;
  logic        rs1_1 = 1'b0, imm_1 = 1'b0;
  logic [3:0]  q4;
  logic        q1, busy4, busy1, done4, done1;
  logic [1:0]  lsb4, lsb1;
  logic [31:0] adr4, adr1, ext4, ext1;
  int          checks = 0, failures = 0;
  logic [3:0]  exp4[$];
  logic        exp1[$];
  typedef struct {
    logic [1:0]  m;
    logic [31:0] r, im;
    logic        re, ie, cl, sg;
    logic [31:0] exp;
  } vec_t;
  vec_t        tv[12];
  logic [31:0] cur;

  always #5 clk = ~clk;

  serv_bufreg_wide #(.W(4), .MDU(1'b1)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start4), .i_mode(mode), .i_rs1_en(rs1_en),
    .i_imm_en(imm_en), .i_clr_lsb(clr), .i_sh_signed(sgn), .i_mdu_op(mdu_op),
    .i_rs1(rs1_4), .i_imm(imm_4), .o_q(q4), .o_busy(busy4), .o_done(done4),
    .o_lsb(lsb4), .o_dbus_adr(adr4), .o_ext_rs1(ext4));

  serv_bufreg_wide #(.W(1), .MDU(1'b0)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .i_mode(mode), .i_rs1_en(rs1_en),
    .i_imm_en(imm_en), .i_clr_lsb(clr), .i_sh_signed(sgn), .i_mdu_op(mdu_op),
    .i_rs1(rs1_1), .i_imm(imm_1), .o_q(q1), .o_busy(busy1), .o_done(done1),
    .o_lsb(lsb1), .o_dbus_adr(adr1), .o_ext_rs1(ext1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (busy4) begin
      if (exp4.size() == 0) begin
        checks++; failures++;
        $display("FAIL q4_extra_beat actual=%h required=none", q4);
      end else chk("q4", 32'(q4), 32'(exp4.pop_front()));
    end
    if (busy1) begin
      if (exp1.size() == 0) begin
        checks++; failures++;
        $display("FAIL q1_extra_beat actual=%h required=none", q1);
      end else chk("q1", 32'(q1), 32'(exp1.pop_front()));
    end
  end

  task automatic pass4(input logic [1:0] m, input logic [31:0] r, input logic [31:0] im,
                       input logic re, input logic ie, input logic cl, input logic sg,
                       input logic [31:0] init, input bit poke);
    start4 = 1'b1; mode = m; rs1_en = re; imm_en = ie; clr = cl; sgn = sg;
    @(posedge clk); #1 start4 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      rs1_4 = r[4*k +: 4]; imm_4 = im[4*k +: 4];
      start4 = poke && (k == 2);
      exp4.push_back((m == 2'b00 || m == 2'b01) ? init[4*k +: 4] : (m == 2'b10) ? init[28-4*k +: 4] : 4'h0);
      @(posedge clk); #1;
    end
    start4 = 1'b0;
    chk("done4_at_n_plus_1", {31'd0, done4}, 32'd1);
    chk("busy4_in_done", {31'd0, busy4}, 32'd0);
    @(posedge clk); #1;
    chk("done4_one_cycle", {30'd0, done4, busy4}, 32'd0);
  endtask

  task automatic pass1(input logic [1:0] m, input logic [31:0] r, input logic [31:0] im, input logic [31:0] init);
    start1 = 1'b1; mode = m; rs1_en = 1'b1; imm_en = 1'b1; clr = 1'b0; sgn = 1'b0;
    @(posedge clk); #1 start1 = 1'b0;
    for (int k = 0; k < 32; k++) begin
      rs1_1 = r[k]; imm_1 = im[k];
      exp1.push_back((m == 2'b00 || m == 2'b01) ? init[k] : (m == 2'b10) ? init[31-k] : 1'b0);
      @(posedge clk); #1;
    end
    chk("done1_at_n_plus_1", {31'd0, done1}, 32'd1);
    @(posedge clk); #1;
    chk("done1_one_cycle", {30'd0, done1, busy1}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int seen;
    tv[0]  = '{2'b00, 32'h0000_1000, 32'h0000_0FFF, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_1FFF};
    tv[1]  = '{2'b00, 32'h0000_0100, 32'h0000_0007, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0106};
    tv[2]  = '{2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0000};
    tv[3]  = '{2'b00, 32'h8000_0010, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_0010};
    tv[4]  = '{2'b01, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF};
    tv[5]  = '{2'b00, 32'h8000_0010, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_0010};
    tv[6]  = '{2'b01, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000};
    tv[7]  = '{2'b00, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0001};
    tv[8]  = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0001};
    tv[9]  = '{2'b10, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000};
    tv[10] = '{2'b00, 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b1, 1'b0, 1'b0, 32'h2345_6789};
    tv[11] = '{2'b00, 32'hFFFF_FFFF, 32'h0000_0003, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0003};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs4", {q4, busy4, done4, lsb4}, 32'd0);
    chk("rst_ext4", ext4, 32'd0);
    chk("rst_adr4", adr4, 32'd0);
    chk("rst_outputs1", {28'd0, q1, busy1, done1, lsb1[0]}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    cur = 32'd0;
    for (int i = 0; i < 12; i++) begin
      pass4(tv[i].m, tv[i].r, tv[i].im, tv[i].re, tv[i].ie, tv[i].cl, tv[i].sg, cur, i == 3);
      chk($sformatf("vec%0d_data", i), ext4, tv[i].exp);
      if (i == 0) begin
        chk("vec0_adr", adr4, 32'h0000_1FFC);
        chk("vec0_lsb", {30'd0, lsb4}, 32'd3);
      end
      cur = tv[i].exp;
    end
    mdu_op = 1'b1; #1;
    chk("mdu1_lsb_forced", {30'd0, lsb4}, 32'd0);
    mdu_op = 1'b0; #1;
    chk("mdu1_lsb_free", {30'd0, lsb4}, 32'd3);
    start4 = 1'b1; mode = 2'b00; rs1_en = 1'b1; imm_en = 1'b1; clr = 1'b0;
    @(posedge clk); #1 start4 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rs1_4 = 4'hF; imm_4 = 4'hF;
      exp4.push_back(cur[4*k +: 4]);
      @(posedge clk); #1;
    end
    rst_n = 1'b0; #1;
    chk("abort_busy", {31'd0, busy4}, 32'd0);
    chk("abort_data", ext4, 32'd0);
    chk("abort_sb_empty", exp4.size(), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done4 || busy4) seen++;
    end
    chk("abort_no_done", seen, 32'd0);
    pass4(2'b00, 32'd5, 32'd3, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("post_abort_sum", ext4, 32'd8);
    pass1(2'b00, 32'd1, 32'd0, 32'd0);
    chk("w1_load", ext1, 32'd1);
    pass1(2'b10, 32'd0, 32'd0, 32'd1);
    chk("w1_shl", ext1, 32'd0);
    pass1(2'b00, 32'h0000_1000, 32'h0000_0FFF, 32'd0);
    chk("w1_addr_data", ext1, 32'h0000_1FFF);
    chk("w1_addr_adr", adr1, 32'h0000_1FFC);
    mdu_op = 1'b1; #1;
    chk("mdu0_lsb_not_forced", {30'd0, lsb1}, 32'd3);
    mdu_op = 1'b0;
    chk("sb4_drained", exp4.size(), 32'd0);
    chk("sb1_drained", exp1.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
